// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data memory controller.
// Provides the controller state encoding and the MIPS load/store opcodes
// so the decoder, the controller and the tests use the same values.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] OP_LW = 6'd35;
    localparam logic [5:0] OP_SW = 6'd43;

endpackage

// File: rtl/dmem_ram.sv
// Word-organised synchronous single-port data RAM.
// Ports:
//   clk  - clock, rising edge
//   we   - write enable; din is written to word idx on the clock edge
//   idx  - word index
//   din  - write data
//   dout - registered read data of word idx (old contents on a write cycle)
// Contents are deliberately not reset.
module dmem_ram
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= din;
        end
        dout <= mem[idx];
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory controller: serves one load or store at a time
// from the control decoder strobes, with WAIT_CYCLES wait states, and
// stalls the pipeline until the access completes.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   MemRead  - load request
//   MemWrite - store request
//   addr     - byte address (word index taken from addr[ADDR_WIDTH+1:2])
//   wdata    - store data
//   rdata    - load data, updated when a load commits, held otherwise
//   stall    - freezes PC and pipeline registers while high
//   mem_err  - illegal request (both strobes or misaligned), combinational
module data_mem_ctrl #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [31:0]           addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  stall,
    output logic                  mem_err
);

    import mem_pkg::*;

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    state_t                  state, state_next;
    logic [3:0]              cnt, cnt_next;
    logic                    op_wr_q;
    logic [ADDR_WIDTH-1:0]   idx_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    load_done_q;
    logic [DATA_WIDTH-1:0]   rdata_hold;

    logic                    in_idle;
    logic                    legal;
    logic                    commit;
    logic                    commit_wr;
    logic                    commit_rd;
    logic [ADDR_WIDTH-1:0]   ram_idx;
    logic [DATA_WIDTH-1:0]   ram_din;
    logic [DATA_WIDTH-1:0]   ram_dout;
    logic                    unused_addr;

    // Upper address bits wrap away.
    assign unused_addr = ^addr[31:ADDR_WIDTH+2];

    // Gated by rst_n so a request held during reset neither stalls nor errors.
    assign in_idle = rst_n && (state == IDLE);
    assign legal   = in_idle && (MemRead ^ MemWrite) && (addr[1:0] == 2'b00);
    assign mem_err = in_idle && (MemRead || MemWrite) &&
                     ((MemRead && MemWrite) || (addr[1:0] != 2'b00));

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        commit     = 1'b0;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                stall = legal;
                if (legal) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = DONE;
                        commit     = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (cnt == 4'd0) begin
                    state_next = DONE;
                    commit     = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // With zero wait states the commit happens on the accepting edge, so the
    // RAM is addressed straight from the requester while in IDLE and from the
    // capture registers otherwise.
    assign ram_idx   = (state == IDLE) ? addr[ADDR_WIDTH+1:2] : idx_q;
    assign ram_din   = (state == IDLE) ? wdata : wdata_q;
    assign commit_wr = commit && ((state == IDLE) ? MemWrite : op_wr_q);
    assign commit_rd = commit && !((state == IDLE) ? MemWrite : op_wr_q);

    dmem_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (commit_wr),
        .idx  (ram_idx),
        .din  (ram_din),
        .dout (ram_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            op_wr_q     <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            load_done_q <= 1'b0;
            rdata_hold  <= '0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            load_done_q <= commit_rd;
            if (load_done_q) begin
                rdata_hold <= ram_dout;
            end
            if (legal) begin
                op_wr_q <= MemWrite;
                idx_q   <= addr[ADDR_WIDTH+1:2];
                wdata_q <= wdata;
            end
        end
    end

    // The RAM's own output register supplies the load data in the DONE cycle;
    // rdata_hold (which is reset) keeps it afterwards, so rdata is always a
    // register output and reads 0 out of reset.
    assign rdata = load_done_q ? ram_dout : rdata_hold;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl: one instance with two
// wait states and one with none, sharing clock and reset.
module tb_data_mem_ctrl;

    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        rd_a, wr_a, stall_a, err_a;
    logic [31:0] addr_a, wd_a, rdata_a;
    logic        rd_b, wr_b, stall_b, err_b;
    logic [31:0] addr_b, wd_b, rdata_b;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(
        .ADDR_WIDTH  (8),
        .DATA_WIDTH  (32),
        .WAIT_CYCLES (2)
    ) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .MemRead  (rd_a),
        .MemWrite (wr_a),
        .addr     (addr_a),
        .wdata    (wd_a),
        .rdata    (rdata_a),
        .stall    (stall_a),
        .mem_err  (err_a)
    );

    data_mem_ctrl #(
        .ADDR_WIDTH  (8),
        .DATA_WIDTH  (32),
        .WAIT_CYCLES (0)
    ) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .MemRead  (rd_b),
        .MemWrite (wr_b),
        .addr     (addr_b),
        .wdata    (wd_b),
        .rdata    (rdata_b),
        .stall    (stall_b),
        .mem_err  (err_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit b, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (b) begin
            rd_b = r; wr_b = w; addr_b = a; wd_b = d;
        end else begin
            rd_a = r; wr_a = w; addr_a = a; wd_a = d;
        end
    endtask

    function automatic logic cur_stall(input bit b);
        return b ? stall_b : stall_a;
    endfunction

    // Called just after a rising edge. Presents the request, counts stall
    // cycles (bounded), checks rdata in the first non-stalled (DONE) cycle,
    // then clears the strobes in the following IDLE cycle.
    task automatic access(input bit b, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] d, input int exp_stall,
                          input logic [31:0] exp_rd, input bit drop, input string tag);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        drive(b, op == OP_LW, op == OP_SW, a, d);
        @(negedge clk);
        check({tag, "_err"}, {31'd0, b ? err_b : err_a}, 32'd0);
        for (int i = 0; i < 40 && !done; i++) begin
            if (cur_stall(b)) begin
                n++;
                @(posedge clk);
                #1;
                if (drop) drive(b, 1'b0, 1'b0, '0, '0);
                @(negedge clk);
            end else begin
                done = 1'b1;
            end
        end
        check({tag, "_stall"}, 32'(n), 32'(exp_stall));
        check({tag, "_rdata"}, b ? rdata_b : rdata_a, exp_rd);
        @(posedge clk);
        #1;
        drive(b, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a load request held on both instances
        rst_n = 1'b0;
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h10, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall_a", {31'd0, stall_a}, 32'd0);
        check("rst_rdata_a", rdata_a, 32'd0);
        check("rst_err_a",   {31'd0, err_a}, 32'd0);
        check("rst_stall_b", {31'd0, stall_b}, 32'd0);
        check("rst_rdata_b", rdata_b, 32'd0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Two wait states: preload, store, load
        access(0, OP_SW, 32'h20,  32'h0000_0000, 3, 32'h0,         0, "sw20_pre");
        access(0, OP_SW, 32'h10,  32'hDEAD_BEEF, 3, 32'h0,         0, "sw10");
        access(0, OP_LW, 32'h10,  32'h0,         3, 32'hDEAD_BEEF, 0, "lw10");

        // Misaligned load: error, no stall, rdata held, state unchanged
        drive(0, 1'b1, 1'b0, 32'h13, 32'h0);
        @(negedge clk);
        check("misal_err",   {31'd0, err_a}, 32'd1);
        check("misal_stall", {31'd0, stall_a}, 32'd0);
        check("misal_rdata", rdata_a, 32'hDEAD_BEEF);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("misal_stall2", {31'd0, stall_a}, 32'd0);
        @(posedge clk);
        #1;

        // Both strobes: error, and the store must not happen
        drive(0, 1'b1, 1'b1, 32'h10, 32'h1111_1111);
        @(negedge clk);
        check("both_err",   {31'd0, err_a}, 32'd1);
        check("both_stall", {31'd0, stall_a}, 32'd0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, '0, '0);
        access(0, OP_LW, 32'h10,  32'h0,         3, 32'hDEAD_BEEF, 0, "lw10_after_both");

        // Address wrap, with strobes dropped during WAIT
        access(0, OP_SW, 32'h400, 32'h0000_1234, 3, 32'hDEAD_BEEF, 1, "sw400_drop");
        access(0, OP_LW, 32'h000, 32'h0,         3, 32'h0000_1234, 0, "lw000_wrap");

        // Reset in the first WAIT cycle abandons the store
        drive(0, 1'b0, 1'b1, 32'h20, 32'hAAAA_5555);
        @(negedge clk);
        check("rstw_stall0", {31'd0, stall_a}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstw_stall_in_rst", {31'd0, stall_a}, 32'd0);
        drive(0, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        access(0, OP_LW, 32'h20,  32'h0,         3, 32'h0,         0, "lw20_after_rst");

        // Zero wait states, back-to-back accesses
        access(1, OP_SW, 32'h8,   32'hCAFE_F00D, 1, 32'h0,         0, "b_sw8");
        access(1, OP_SW, 32'hC,   32'h0BAD_F00D, 1, 32'h0,         0, "b_swC");
        access(1, OP_LW, 32'h8,   32'h0,         1, 32'hCAFE_F00D, 0, "b_lw8");
        access(1, OP_LW, 32'hC,   32'h0,         1, 32'h0BAD_F00D, 0, "b_lwC");
        @(negedge clk);
        check("b_hold", rdata_b, 32'h0BAD_F00D);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
